// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: register offsets, bit positions and FSM encoding.
package spi_pkg;

    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_STAT = 3'd1;
    localparam logic [2:0] REG_DATA = 3'd2;
    localparam logic [2:0] REG_SSEL = 3'd3;
    localparam logic [2:0] REG_DIV  = 3'd4;

    localparam int unsigned CTRL_SPE  = 7;
    localparam int unsigned CTRL_IE   = 6;
    localparam int unsigned CTRL_CPOL = 1;
    localparam int unsigned CTRL_CPHA = 0;

    localparam int unsigned STAT_SPIF = 7;
    localparam int unsigned STAT_WCOL = 6;
    localparam int unsigned STAT_BUSY = 0;

    // Writable CTRL bits; the rest read back as zero.
    localparam logic [7:0] CTRL_MASK = 8'hC3;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StEdge1,
        StEdge2,
        StDone
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: tick pulses every DIV+1 enabled clocks, compared against the live divisor.
module spi_clk_div #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i & ~clr_i & (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == div_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Byte-wide SPI master on the 68k IO bus: CTRL/STAT/DATA/SSEL/DIV registers and the shift FSM.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned NUM_SS = 4
) (
    input  logic              Clock,
    input  logic              Reset_H,
    input  logic              Enable_H,
    input  logic [2:0]        Address,
    input  logic              RW,
    input  logic [7:0]        DataIn,
    output logic [7:0]        DataOut,
    output logic              Irq_H,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_L
);

    spi_state_e        state_q, state_d;
    logic              enable_q;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [NUM_SS-1:0] ssel_q, ssel_d;
    logic              spif_q, spif_d;
    logic              wcol_q, wcol_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              sclk_ph_q, sclk_ph_d;
    logic              mosi_q, mosi_d;
    logic              miso_s_q, miso_s_d;
    logic              div_clr, tick, busy;

    // One register action per bus cycle regardless of how long the strobe is held.
    logic acc, wr, rd, wr_data, rd_data;
    assign acc     = Enable_H & ~enable_q;
    assign wr      = acc & ~RW;
    assign rd      = acc & RW;
    assign wr_data = wr && (Address == REG_DATA);
    assign rd_data = rd && (Address == REG_DATA);

    logic spe, cpha, cpol;
    assign spe  = ctrl_q[CTRL_SPE];
    assign cpha = ctrl_q[CTRL_CPHA];
    assign cpol = ctrl_q[CTRL_CPOL];
    assign busy = (state_q == StLead) || (state_q == StEdge1) || (state_q == StEdge2);

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk_i  (Clock),
        .rst_i  (Reset_H),
        .clr_i  (div_clr),
        .en_i   (busy),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        ssel_d    = ssel_q;
        spif_d    = spif_q;
        wcol_d    = wcol_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sclk_ph_d = sclk_ph_q;
        mosi_d    = mosi_q;
        miso_s_d  = miso_s_q;
        div_clr   = 1'b0;

        if (wr) begin
            case (Address)
                REG_CTRL: ctrl_d = DataIn & CTRL_MASK;
                REG_SSEL: ssel_d = DataIn[NUM_SS-1:0];
                REG_DIV:  div_d  = DataIn[DIV_W-1:0];
                default:  ;
            endcase
        end
        if (rd_data) begin
            spif_d = 1'b0;
            wcol_d = 1'b0;
        end
        if (wr_data && busy) begin
            wcol_d = 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                // Completion set is applied after the read clear so it wins a same-cycle read.
                if (state_q == StDone) begin
                    spif_d = 1'b1;
                end
                state_d = StIdle;
                if (wr_data) begin
                    shreg_d = DataIn;
                    if (spe) begin
                        state_d   = StLead;
                        bit_cnt_d = '0;
                        div_clr   = 1'b1;
                        if (!cpha) begin
                            mosi_d = DataIn[7];
                        end
                    end
                end
            end
            StLead, StEdge2: begin
                if (!spe) begin
                    state_d   = StIdle;
                    sclk_ph_d = 1'b0;
                    div_clr   = 1'b1;
                end else if (tick) begin
                    state_d   = StEdge1;
                    sclk_ph_d = ~sclk_ph_q;
                    if (cpha) begin
                        mosi_d = shreg_q[7];
                    end else begin
                        miso_s_d = MISO;
                    end
                end
            end
            StEdge1: begin
                if (!spe) begin
                    state_d   = StIdle;
                    sclk_ph_d = 1'b0;
                    div_clr   = 1'b1;
                end else if (tick) begin
                    sclk_ph_d = ~sclk_ph_q;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (cpha) begin
                        shreg_d = {shreg_q[6:0], MISO};
                    end else begin
                        shreg_d = {shreg_q[6:0], miso_s_q};
                        mosi_d  = shreg_q[6];
                    end
                    state_d = (bit_cnt_q == 3'd7) ? StDone : StEdge2;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state_q   <= StIdle;
            enable_q  <= 1'b0;
            ctrl_q    <= '0;
            div_q     <= '0;
            ssel_q    <= '0;
            spif_q    <= 1'b0;
            wcol_q    <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_ph_q <= 1'b0;
            mosi_q    <= 1'b0;
            miso_s_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            enable_q  <= Enable_H;
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            ssel_q    <= ssel_d;
            spif_q    <= spif_d;
            wcol_q    <= wcol_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_ph_q <= sclk_ph_d;
            mosi_q    <= mosi_d;
            miso_s_q  <= miso_s_d;
        end
    end

    // SCLK is a phase bit XOR live CPOL, so it rests at CPOL whenever the phase is zero.
    assign SCLK  = sclk_ph_q ^ cpol;
    assign MOSI  = mosi_q;
    assign SS_L  = ~ssel_q;
    assign Irq_H = spif_q & ctrl_q[CTRL_IE];

    logic [7:0] rdata;
    always_comb begin
        rdata = 8'h00;
        case (Address)
            REG_CTRL: rdata = ctrl_q;
            REG_STAT: rdata = {spif_q, wcol_q, 5'b00000, busy};
            REG_DATA: rdata = shreg_q;
            REG_SSEL: rdata = 8'(ssel_q);
            REG_DIV:  rdata = 8'(div_q);
            default:  rdata = 8'h00;
        endcase
    end
    assign DataOut = (Enable_H && RW) ? rdata : 8'h00;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: register table plus hand-written transfer sequences.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic       clock = 1'b0;
    logic       reset_h, enable_h, rw, irq_h, sclk, mosi, miso;
    logic [2:0] address;
    logic [7:0] data_in, data_out;
    logic [3:0] ss_l;
    logic       miso_loop, miso_fix;

    int checks = 0;
    int failures = 0;
    int unsigned sclk_rises = 0;
    logic [7:0] mosi_bits = 8'h00;

    assign miso = miso_loop ? mosi : miso_fix;

    spi_master_ctrl #(
        .DIV_W  (8),
        .NUM_SS (4)
    ) dut (
        .Clock    (clock),
        .Reset_H  (reset_h),
        .Enable_H (enable_h),
        .Address  (address),
        .RW       (rw),
        .DataIn   (data_in),
        .DataOut  (data_out),
        .Irq_H    (irq_h),
        .SCLK     (sclk),
        .MOSI     (mosi),
        .MISO     (miso),
        .SS_L     (ss_l)
    );

    always #5 clock = ~clock;

    // Slave-side view: capture MOSI on every rising SCLK.
    always @(posedge sclk) begin
        sclk_rises <= sclk_rises + 1;
        mosi_bits  <= {mosi_bits[6:0], mosi};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clock);
        enable_h = 1'b1; rw = 1'b0; address = a; data_in = d;
        @(negedge clock);
        enable_h = 1'b0; rw = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clock);
        enable_h = 1'b1; rw = 1'b1; address = a;
        #1 d = data_out;
        @(negedge clock);
        enable_h = 0;
    endtask

    // Negedge index (write task returns at 1) where SPIF/IRQ first reads 1; -1 if never.
    task automatic wait_done(input bit use_irq, output int lat);
        lat = -1;
        for (int n = 2; n <= 60; n++) begin
            @(negedge clock);
            if (!use_irq) begin
                enable_h = 1'b1; rw = 1'b1; address = REG_STAT;
            end
            #1;
            if (lat < 0 && (use_irq ? irq_h : data_out[STAT_SPIF])) lat = n;
        end
        enable_h = 1'b0;
    endtask

    typedef struct {
        logic       rd;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [7:0]  rdv;
    int          lat;
    int unsigned base;

    initial begin
        vecs[0]  = '{1'b1, REG_STAT, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 3'd5,     8'h00, 8'h00};
        vecs[2]  = '{1'b1, 3'd6,     8'h00, 8'h00};
        vecs[3]  = '{1'b1, 3'd7,     8'h00, 8'h00};
        vecs[4]  = '{1'b1, REG_CTRL, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, REG_SSEL, 8'h05, 8'h00};
        vecs[6]  = '{1'b1, REG_SSEL, 8'h00, 8'h05};
        vecs[7]  = '{1'b0, REG_CTRL, 8'h7E, 8'h00};
        vecs[8]  = '{1'b1, REG_CTRL, 8'h00, 8'h42};
        vecs[9]  = '{1'b0, REG_DIV,  8'h07, 8'h00};
        vecs[10] = '{1'b0, 3'd5,     8'hFF, 8'h00};
        vecs[11] = '{1'b1, REG_DIV,  8'h00, 8'h07};

        reset_h = 1'b1; enable_h = 1'b0; rw = 1'b1; address = 3'd0; data_in = 8'h00;
        miso_loop = 1'b1; miso_fix = 1'b0;
        repeat (3) @(negedge clock);
        reset_h = 1'b0;

        check("reset_ss_l", 32'(ss_l), 32'hF);
        check("reset_sclk", 32'(sclk), 32'h0);
        check("reset_irq", 32'(irq_h), 32'h0);
        check("reset_mosi", 32'(mosi), 32'h0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].rd) begin
                bus_read(vecs[i].addr, rdv);
                check($sformatf("vec%0d_read", i), 32'(rdv), 32'(vecs[i].exp));
            end else begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end
        end
        check("ssel_pins", 32'(ss_l), 32'hA);
        bus_write(REG_SSEL, 8'h00);

        // Mode 0, DIV=1, loopback
        bus_write(REG_DIV, 8'h01);
        bus_write(REG_CTRL, 8'h80);
        base = sclk_rises;
        bus_write(REG_DATA, 8'hA5);
        wait_done(1'b0, lat);
        check("m0_latency", 32'(lat), 32'd34);
        check("m0_sclk_pulses", sclk_rises - base, 32'd8);
        check("m0_mosi_bits", 32'(mosi_bits), 32'hA5);
        check("m0_sclk_idle", 32'(sclk), 32'h0);
        bus_read(REG_DATA, rdv);
        check("m0_data", 32'(rdv), 32'hA5);
        bus_read(REG_STAT, rdv);
        check("m0_spif_cleared", 32'(rdv), 32'h00);

        // Long strobe: one held write with DIV=0 starts exactly one frame
        bus_write(REG_DIV, 8'h00);
        base = sclk_rises;
        @(negedge clock);
        enable_h = 1'b1; rw = 1'b0; address = REG_DATA; data_in = 8'h3C;
        repeat (20) @(negedge clock);
        enable_h = 1'b0; rw = 1'b1;
        repeat (30) @(negedge clock);
        check("long_sclk_pulses", sclk_rises - base, 32'd8);
        bus_read(REG_STAT, rdv);
        check("long_stat", 32'(rdv), 32'h80);
        bus_read(REG_DATA, rdv);
        check("long_data", 32'(rdv), 32'h3C);

        // Collision
        bus_write(REG_DIV, 8'h01);
        base = sclk_rises;
        bus_write(REG_DATA, 8'h5A);
        bus_write(REG_DATA, 8'h3C);
        bus_read(REG_STAT, rdv);
        check("col_stat_busy", 32'(rdv), 32'h41);
        repeat (40) @(negedge clock);
        check("col_sclk_pulses", sclk_rises - base, 32'd8);
        check("col_mosi_bits", 32'(mosi_bits), 32'h5A);
        bus_read(REG_STAT, rdv);
        check("col_stat_done", 32'(rdv), 32'hC0);
        bus_read(REG_DATA, rdv);
        check("col_data", 32'(rdv), 32'h5A);
        bus_read(REG_STAT, rdv);
        check("col_stat_clr", 32'(rdv), 32'h00);

        // Mode 3 with interrupt, MISO held high
        bus_write(REG_DIV, 8'h00);
        bus_write(REG_CTRL, 8'hC3);
        check("m3_sclk_idle", 32'(sclk), 32'h1);
        miso_loop = 1'b0; miso_fix = 1'b1;
        base = sclk_rises;
        bus_write(REG_DATA, 8'h96);
        wait_done(1'b1, lat);
        check("m3_irq_latency", 32'(lat), 32'd18);
        check("m3_sclk_pulses", sclk_rises - base, 32'd8);
        check("m3_mosi_bits", 32'(mosi_bits), 32'h96);
        check("m3_sclk_end", 32'(sclk), 32'h1);
        bus_read(REG_DATA, rdv);
        check("m3_data", 32'(rdv), 32'hFF);
        check("m3_irq_cleared", 32'(irq_h), 32'h0);

        // Abort at bit 4
        miso_loop = 1'b1;
        bus_write(REG_CTRL, 8'h80);
        bus_write(REG_DIV, 8'h01);
        base = sclk_rises;
        bus_write(REG_DATA, 8'h5A);
        repeat (16) @(negedge clock);
        bus_write(REG_CTRL, 8'h00);
        check("abort_sclk_before", 32'(sclk), 32'h1);
        @(negedge clock);
        check("abort_sclk_after", 32'(sclk), 32'h0);
        check("abort_rises", sclk_rises - base, 32'd5);
        bus_read(REG_STAT, rdv);
        check("abort_stat", 32'(rdv), 32'h00);
        repeat (40) @(negedge clock);
        bus_read(REG_STAT, rdv);
        check("abort_stat_later", 32'(rdv), 32'h00);
        bus_write(REG_CTRL, 8'h80);
        base = sclk_rises;
        bus_write(REG_DATA, 8'hC3);
        wait_done(1'b0, lat);
        check("restart_latency", 32'(lat), 32'd34);
        check("restart_pulses", sclk_rises - base, 32'd8);
        check("restart_mosi", 32'(mosi_bits), 32'hC3);
        bus_read(REG_DATA, rdv);
        check("restart_data", 32'(rdv), 32'hC3);

        // Reset during a transfer
        bus_write(REG_SSEL, 8'h03);
        bus_write(REG_DATA, 8'h77);
        repeat (5) @(negedge clock);
        reset_h = 1'b1;
        @(negedge clock);
        reset_h = 1'b0;
        check("rst_ss_l", 32'(ss_l), 32'hF);
        check("rst_sclk", 32'(sclk), 32'h0);
        check("rst_mosi", 32'(mosi), 32'h0);
        bus_read(REG_STAT, rdv);
        check("rst_stat", 32'(rdv), 32'h00);
        bus_read(REG_CTRL, rdv);
        check("rst_ctrl", 32'(rdv), 32'h00);
        bus_read(REG_DATA, rdv);
        check("rst_data", 32'(rdv), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
